// File: rtl/sdram_dq_burst_path.sv
// SDRAM DQ data path: registered write-beat driver with DQM, CAS-latency read capture,
// and ownership of the DQ tri-state. Sequenced by WR_START/RD_START from the command FSM.
module sdram_dq_burst_path #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 4,
  parameter int CAS_LAT   = 2
) (
  input  logic                CLK_100M,
  input  logic                RST,
  input  logic                WR_START,
  input  logic                RD_START,
  output logic                WR_REQ,
  input  logic [DATA_W-1:0]   WR_DATA,
  input  logic [DATA_W/8-1:0] WR_MASK,
  output logic [DATA_W-1:0]   RD_DATA,
  output logic                RD_VALID,
  output logic                BUSY,
  output logic                ERR,
  inout  wire  [DATA_W-1:0]   DQ,
  output logic [DATA_W/8-1:0] DQM
);

  localparam int BYTE_W = DATA_W / 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, READ} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [CNT_W-1:0]   lat_cnt, lat_cnt_nxt;
  logic               err_nxt;
  logic               last_beat;
  logic               dq_oe;
  logic [DATA_W-1:0]  dq_out;

  assign last_beat = (beat_cnt == CNT_W'(BURST_LEN - 1));
  assign WR_REQ    = (state == WRITE);
  assign BUSY      = (state != IDLE);
  assign DQ        = dq_oe ? dq_out : {DATA_W{1'bz}};

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    lat_cnt_nxt  = lat_cnt;
    // A start while busy is dropped; in IDLE only a simultaneous write is the loser.
    err_nxt      = BUSY ? (WR_START | RD_START) : (WR_START & RD_START);
    case (state)
      IDLE: begin
        if (RD_START) begin
          state_nxt   = RD_WAIT;
          lat_cnt_nxt = CNT_W'(1);
        end else if (WR_START) begin
          state_nxt    = WRITE;
          beat_cnt_nxt = '0;
        end
      end
      WRITE, READ: begin
        beat_cnt_nxt = beat_cnt + 1'b1;
        if (last_beat) state_nxt = IDLE;
      end
      RD_WAIT: begin
        // Enter READ so that its first cycle is the one carrying the first SDRAM beat.
        lat_cnt_nxt = lat_cnt + 1'b1;
        if (lat_cnt_nxt == CNT_W'(CAS_LAT)) begin
          state_nxt    = READ;
          beat_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      state    <= IDLE;
      beat_cnt <= '0;
      lat_cnt  <= '0;
      ERR      <= 1'b0;
      dq_oe    <= 1'b0;
      DQM      <= '0;
      RD_VALID <= 1'b0;
      RD_DATA  <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_cnt_nxt;
      lat_cnt  <= lat_cnt_nxt;
      ERR      <= err_nxt;
      dq_oe    <= WR_REQ;
      DQM      <= WR_REQ ? WR_MASK : {BYTE_W{1'b0}};
      RD_VALID <= (state == READ);
      if (state == READ) RD_DATA <= DQ;
    end
  end

  // NOTE: pure data register, qualified by dq_oe, so it carries no reset.
  always_ff @(posedge CLK_100M) begin
    if (WR_REQ) dq_out <= WR_DATA;
  end

endmodule

// File: tb/tb_sdram_dq_burst_path.sv
// Directed bench for sdram_dq_burst_path: write/read scoreboards, collisions, reset, turnaround.
module tb_sdram_dq_burst_path;

  logic CLK_100M = 1'b0;
  always #5 CLK_100M = ~CLK_100M;

  logic        RST = 1'b1, WR_START = 1'b0, RD_START = 1'b0;
  logic [15:0] WR_DATA = '0;
  logic [1:0]  WR_MASK = '0;
  logic        WR_REQ, RD_VALID, BUSY, ERR;
  logic [15:0] RD_DATA;
  logic [1:0]  DQM;
  wire  [15:0] DQ;
  logic [15:0] mdl_dq = '0;
  logic        mdl_oe = 1'b0;
  assign DQ = mdl_oe ? mdl_dq : 16'hzzzz;

  logic        RD_START_b = 1'b0, WR_START_b = 1'b0;
  logic [15:0] WR_DATA_b = '0;
  logic [1:0]  WR_MASK_b = '0;
  logic        WR_REQ_b, RD_VALID_b, BUSY_b, ERR_b;
  logic [15:0] RD_DATA_b;
  logic [1:0]  DQM_b;
  wire  [15:0] DQ_b;
  logic [15:0] mdl_dq_b = '0;
  logic        mdl_oe_b = 1'b0;
  assign DQ_b = mdl_oe_b ? mdl_dq_b : 16'hzzzz;

  sdram_dq_burst_path u_dut (
    .CLK_100M(CLK_100M), .RST(RST), .WR_START(WR_START), .RD_START(RD_START),
    .WR_REQ(WR_REQ), .WR_DATA(WR_DATA), .WR_MASK(WR_MASK), .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID), .BUSY(BUSY), .ERR(ERR), .DQ(DQ), .DQM(DQM)
  );

  sdram_dq_burst_path #(.DATA_W(16), .BURST_LEN(8), .CAS_LAT(3)) u_dut_b (
    .CLK_100M(CLK_100M), .RST(RST), .WR_START(WR_START_b), .RD_START(RD_START_b),
    .WR_REQ(WR_REQ_b), .WR_DATA(WR_DATA_b), .WR_MASK(WR_MASK_b), .RD_DATA(RD_DATA_b),
    .RD_VALID(RD_VALID_b), .BUSY(BUSY_b), .ERR(ERR_b), .DQ(DQ_b), .DQM(DQM_b)
  );

  int tests = 0;
  int fails = 0;
  int vb_cnt = 0;
  logic [15:0] rd_q[$];
  logic [15:0] rd_q_b[$];
  logic [17:0] wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK_100M);
    #1;
  endtask

  // Scoreboard side: pop expected beats when the DUT drives DQ or strobes RD_VALID.
  logic [17:0] wr_exp;
  logic [15:0] rd_exp, rd_exp_b;
  always @(negedge CLK_100M) begin
    if (u_dut.dq_oe) begin
      check("wr_drive_expected", 32'(wr_q.size() != 0), 32'd1);
      if (wr_q.size() != 0) begin
        wr_exp = wr_q.pop_front();
        check("wr_dq", 32'(DQ), 32'(wr_exp[15:0]));
        check("wr_dqm", 32'(DQM), 32'(wr_exp[17:16]));
      end
    end else begin
      check("dqm_idle", 32'(DQM), 32'd0);
    end
    if (mdl_oe) check("dq_contention", 32'(u_dut.dq_oe), 32'd0);
    if (mdl_oe_b) check("dq_contention_b", 32'(u_dut_b.dq_oe), 32'd0);
    if (RD_VALID) begin
      check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) begin
        rd_exp = rd_q.pop_front();
        check("rd_data", 32'(RD_DATA), 32'(rd_exp));
      end
    end
    if (RD_VALID_b) begin
      vb_cnt++;
      check("rd_expected_b", 32'(rd_q_b.size() != 0), 32'd1);
      if (rd_q_b.size() != 0) begin
        rd_exp_b = rd_q_b.pop_front();
        check("rd_data_b", 32'(RD_DATA_b), 32'(rd_exp_b));
      end
    end
  end

  logic [15:0] wd[4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
  logic [1:0]  wm[4] = '{2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    // Reset values
    repeat (3) step();
    check("rst_wr_req", 32'(WR_REQ), 32'd0);
    check("rst_rd_valid", 32'(RD_VALID), 32'd0);
    check("rst_rd_data", 32'(RD_DATA), 32'd0);
    check("rst_dqm", 32'(DQM), 32'd0);
    check("rst_err", 32'(ERR), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_dq_oe", 32'(u_dut.dq_oe), 32'd0);
    check("rst_busy_b", 32'(BUSY_b), 32'd0);
    RST = 1'b0;
    step();

    // Write burst, BL=4
    WR_START = 1'b1; step(); WR_START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("wr_req_on", 32'(WR_REQ), 32'd1);
      WR_DATA = wd[i]; WR_MASK = wm[i];
      wr_q.push_back({wm[i], wd[i]});
      step();
    end
    check("wr_req_off", 32'(WR_REQ), 32'd0);
    check("wr_busy_done", 32'(BUSY), 32'd0);
    step();
    check("wr_release", 32'(u_dut.dq_oe), 32'd0);
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);

    // Read CL=2 BL=4 with a WR_START collision mid-burst
    RD_START = 1'b1; step(); RD_START = 1'b0;
    check("rd_busy", 32'(BUSY), 32'd1);
    check("rd_wait_novalid", 32'(RD_VALID), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      mdl_oe = 1'b1; mdl_dq = 16'h5A10 + 16'(i);
      rd_q.push_back(mdl_dq);
      if (i == 0) check("rd_first_novalid", 32'(RD_VALID), 32'd0);
      if (i == 1) WR_START = 1'b1;
      if (i == 2) begin
        WR_START = 1'b0;
        check("coll_err", 32'(ERR), 32'd1);
        check("coll_no_wr_req", 32'(WR_REQ), 32'd0);
      end
      if (i == 3) check("coll_err_pulse", 32'(ERR), 32'd0);
      step();
    end
    mdl_oe = 1'b0;
    check("rd_last_valid", 32'(RD_VALID), 32'd1);
    check("rd_busy_done", 32'(BUSY), 32'd0);
    step();
    check("rd_valid_off", 32'(RD_VALID), 32'd0);
    check("rd_data_hold", 32'(RD_DATA), 32'h5A13);
    check("rd_q_drained", 32'(rd_q.size()), 32'd0);

    // Both starts in IDLE: read wins, ERR pulses
    WR_START = 1'b1; RD_START = 1'b1; step(); WR_START = 1'b0; RD_START = 1'b0;
    check("both_err", 32'(ERR), 32'd1);
    check("both_no_write", 32'(WR_REQ), 32'd0);
    check("both_busy", 32'(BUSY), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      mdl_oe = 1'b1; mdl_dq = 16'hC3C0 + 16'(i);
      rd_q.push_back(mdl_dq);
      if (i == 0) check("both_err_pulse", 32'(ERR), 32'd0);
      step();
    end
    mdl_oe = 1'b0;
    step();
    check("both_rd_drained", 32'(rd_q.size()), 32'd0);
    check("both_wr_none", 32'(wr_q.size()), 32'd0);

    // Back-to-back write then read on the first BUSY=0 cycle
    WR_START = 1'b1; step(); WR_START = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b2b_wr_req", 32'(WR_REQ), 32'd1);
      WR_DATA = 16'hB000 + 16'(i); WR_MASK = 2'(i);
      wr_q.push_back({WR_MASK, WR_DATA});
      step();
    end
    check("b2b_idle", 32'(BUSY), 32'd0);
    RD_START = 1'b1; step(); RD_START = 1'b0;
    check("b2b_turnaround", 32'(u_dut.dq_oe), 32'd0);
    check("b2b_rd_busy", 32'(BUSY), 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      mdl_oe = 1'b1; mdl_dq = 16'h7E00 + 16'(i);
      rd_q.push_back(mdl_dq);
      step();
    end
    mdl_oe = 1'b0;
    step();
    check("b2b_rd_drained", 32'(rd_q.size()), 32'd0);
    check("b2b_wr_drained", 32'(wr_q.size()), 32'd0);

    // Reset held 3 cycles in the middle of a write burst
    WR_START = 1'b1; step(); WR_START = 1'b0;
    WR_DATA = 16'hD001; WR_MASK = 2'b11;
    wr_q.push_back({WR_MASK, WR_DATA});
    step();
    check("rstw_wr_req", 32'(WR_REQ), 32'd1);
    RST = 1'b1; WR_DATA = 16'hD002; WR_MASK = 2'b01;
    step();
    check("rstw_wr_req_off", 32'(WR_REQ), 32'd0);
    check("rstw_busy", 32'(BUSY), 32'd0);
    check("rstw_dq_oe", 32'(u_dut.dq_oe), 32'd0);
    check("rstw_dqm", 32'(DQM), 32'd0);
    step(); step();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rstw_no_beats", 32'(WR_REQ), 32'd0);
      step();
    end
    check("rstw_q_drained", 32'(wr_q.size()), 32'd0);

    // Instance b: CL=3 BL=8 read
    RD_START_b = 1'b1; step(); RD_START_b = 1'b0;
    step(); step();
    for (int i = 0; i < 8; i++) begin
      mdl_oe_b = 1'b1; mdl_dq_b = 16'h8800 + 16'(i);
      rd_q_b.push_back(mdl_dq_b);
      if (i == 0) check("b_first_novalid", 32'(RD_VALID_b), 32'd0);
      step();
    end
    mdl_oe_b = 1'b0;
    check("b_last_valid", 32'(RD_VALID_b), 32'd1);
    step();
    check("b_valid_off", 32'(RD_VALID_b), 32'd0);
    check("b_pulse_count", 32'(vb_cnt), 32'd8);
    check("b_rd_drained", 32'(rd_q_b.size()), 32'd0);
    check("b_busy_done", 32'(BUSY_b), 32'd0);
    check("b_data_hold", 32'(RD_DATA_b), 32'h8807);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
